// File: rtl/id_stage_hs_pkg.sv
// Shared constants for the handshaked RV32I decode stage: opcodes, branch funct3 codes,
// squash state encoding and opcode classification helpers.
package id_stage_hs_pkg;

  localparam int unsigned OPC_W = 7;
  localparam int unsigned F3_W  = 3;

  localparam logic [OPC_W-1:0] OPC_LUI    = 7'b0110111;
  localparam logic [OPC_W-1:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [OPC_W-1:0] OPC_JAL    = 7'b1101111;
  localparam logic [OPC_W-1:0] OPC_JALR   = 7'b1100111;
  localparam logic [OPC_W-1:0] OPC_BRANCH = 7'b1100011;
  localparam logic [OPC_W-1:0] OPC_LOAD   = 7'b0000011;
  localparam logic [OPC_W-1:0] OPC_STORE  = 7'b0100011;
  localparam logic [OPC_W-1:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [OPC_W-1:0] OPC_OP     = 7'b0110011;

  localparam logic [F3_W-1:0] F3_BEQ  = 3'b000;
  localparam logic [F3_W-1:0] F3_BNE  = 3'b001;
  localparam logic [F3_W-1:0] F3_BLT  = 3'b100;
  localparam logic [F3_W-1:0] F3_BGE  = 3'b101;
  localparam logic [F3_W-1:0] F3_BLTU = 3'b110;
  localparam logic [F3_W-1:0] F3_BGEU = 3'b111;

  typedef enum logic {
    ST_RUN    = 1'b0,
    ST_SQUASH = 1'b1
  } state_e;

  function automatic logic opc_known(input logic [OPC_W-1:0] opc);
    return (opc == OPC_LUI) || (opc == OPC_AUIPC) || (opc == OPC_JAL) ||
           (opc == OPC_JALR) || (opc == OPC_BRANCH) || (opc == OPC_LOAD) ||
           (opc == OPC_STORE) || (opc == OPC_OP_IMM) || (opc == OPC_OP);
  endfunction

  function automatic logic reads_rs1(input logic [OPC_W-1:0] opc);
    return (opc == OPC_JALR) || (opc == OPC_BRANCH) || (opc == OPC_LOAD) ||
           (opc == OPC_STORE) || (opc == OPC_OP_IMM) || (opc == OPC_OP);
  endfunction

  function automatic logic reads_rs2(input logic [OPC_W-1:0] opc);
    return (opc == OPC_BRANCH) || (opc == OPC_STORE) || (opc == OPC_OP);
  endfunction

endpackage

// File: rtl/id_branch_unit.sv
// Combinational control-transfer resolution: branch compare, target add and take decision.
module id_branch_unit
  import id_stage_hs_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic [OPC_W-1:0] opcode_i,
  input  logic [F3_W-1:0]  funct3_i,
  input  logic [XLEN-1:0]  pc_i,
  input  logic [XLEN-1:0]  op1_i,
  input  logic [XLEN-1:0]  op2_i,
  input  logic [XLEN-1:0]  imm_i,
  output logic             take_c_o,
  output logic [XLEN-1:0]  target_c_o
);

  logic            cond;
  logic [XLEN-1:0] jalr_sum;

  assign jalr_sum = op1_i + imm_i;

  always_comb begin
    cond = 1'b0;
    case (funct3_i)
      F3_BEQ:  cond = (op1_i == op2_i);
      F3_BNE:  cond = (op1_i != op2_i);
      F3_BLT:  cond = ($signed(op1_i) <  $signed(op2_i));
      F3_BGE:  cond = ($signed(op1_i) >= $signed(op2_i));
      F3_BLTU: cond = (op1_i <  op2_i);
      F3_BGEU: cond = (op1_i >= op2_i);
      default: cond = 1'b0;
    endcase
  end

  always_comb begin
    take_c_o   = 1'b0;
    target_c_o = '0;
    case (opcode_i)
      OPC_JAL: begin
        take_c_o   = 1'b1;
        target_c_o = pc_i + imm_i;
      end
      OPC_JALR: begin
        take_c_o   = 1'b1;
        target_c_o = {jalr_sum[XLEN-1:1], 1'b0};
      end
      OPC_BRANCH: begin
        take_c_o   = cond;
        target_c_o = pc_i + imm_i;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/id_stage_hs.sv
// RV32I decode stage with folded ID/EX register, valid/ready flow control, load-use stall
// and post-redirect squash. Optional ID_FWD_EN adds EX/MEM operand forwarding.
module id_stage_hs
  import id_stage_hs_pkg::*;
#(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned RAW_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [XLEN-1:0]   pc_i,
  input  logic [31:0]       inst_i,
  output logic [RAW_W-1:0]  reg1_addr_o,
  output logic [RAW_W-1:0]  reg2_addr_o,
  input  logic [XLEN-1:0]   reg1_data_i,
  input  logic [XLEN-1:0]   reg2_data_i,
  input  logic              ex_load_i,
  input  logic [RAW_W-1:0]  ex_wd_i,
`ifdef ID_FWD_EN
  input  logic              ex_wreg_i,
  input  logic [XLEN-1:0]   ex_wdata_i,
  input  logic              mem_wreg_i,
  input  logic [RAW_W-1:0]  mem_wd_i,
  input  logic [XLEN-1:0]   mem_wdata_i,
`endif
  input  logic              flush_i,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [XLEN-1:0]   pc_o,
  output logic [XLEN-1:0]   reg1_o,
  output logic [XLEN-1:0]   reg2_o,
  output logic [XLEN-1:0]   imm_o,
  output logic [OPC_W-1:0]  opcode_o,
  output logic [F3_W-1:0]   funct_o,
  output logic [RAW_W-1:0]  wd_o,
  output logic              wreg_o,
  output logic              illegal_o,
  output logic              redirect_o,
  output logic [XLEN-1:0]   redirect_addr_o
);

  logic [OPC_W-1:0] opc;
  logic [F3_W-1:0]  f3;
  logic [RAW_W-1:0] rd, rs1, rs2;
  logic             known, rd1, rd2;
  logic [31:0]      imm32;
  logic [XLEN-1:0]  imm, src1, src2, op1, op2, target_c;
  logic             take_c, hazard, tgt_hit, run_beat, norm_ready, fire;

  state_e           state_q, state_d;
  logic [XLEN-1:0]  tgt_q, tgt_d;
  logic             valid_q, valid_d;
  logic [XLEN-1:0]  pc_q, pc_d, reg1_q, reg1_d, reg2_q, reg2_d, imm_q, imm_d;
  logic [OPC_W-1:0] opc_q, opc_d;
  logic [F3_W-1:0]  f3_q, f3_d;
  logic [RAW_W-1:0] wd_q, wd_d;
  logic             wreg_q, wreg_d, ill_q, ill_d;

  assign opc   = inst_i[6:0];
  assign f3    = inst_i[14:12];
  assign rd    = RAW_W'(inst_i[11:7]);
  assign rs1   = RAW_W'(inst_i[19:15]);
  assign rs2   = RAW_W'(inst_i[24:20]);
  assign known = opc_known(opc);
  assign rd1   = reads_rs1(opc);
  assign rd2   = reads_rs2(opc);

  assign reg1_addr_o = rs1;
  assign reg2_addr_o = rs2;

  // Immediate per instruction format, built at 32 bits then sign-extended to XLEN.
  always_comb begin
    imm32 = '0;
    case (opc)
      OPC_JALR, OPC_LOAD, OPC_OP_IMM: imm32 = {{20{inst_i[31]}}, inst_i[31:20]};
      OPC_STORE:  imm32 = {{20{inst_i[31]}}, inst_i[31:25], inst_i[11:7]};
      OPC_BRANCH: imm32 = {{19{inst_i[31]}}, inst_i[31], inst_i[7], inst_i[30:25],
                           inst_i[11:8], 1'b0};
      OPC_LUI, OPC_AUIPC: imm32 = {inst_i[31:12], 12'b0};
      OPC_JAL:    imm32 = {{11{inst_i[31]}}, inst_i[31], inst_i[19:12], inst_i[20],
                           inst_i[30:21], 1'b0};
      default:    imm32 = '0;
    endcase
  end

  assign imm = XLEN'($signed(imm32));

`ifdef ID_FWD_EN
  // EX result wins over MEM; a load in EX has no data yet and is covered by the stall.
  always_comb begin
    src1 = reg1_data_i;
    src2 = reg2_data_i;
    if (ex_wreg_i && !ex_load_i && (ex_wd_i == rs1) && (rs1 != '0)) src1 = ex_wdata_i;
    else if (mem_wreg_i && (mem_wd_i == rs1) && (rs1 != '0))       src1 = mem_wdata_i;
    if (ex_wreg_i && !ex_load_i && (ex_wd_i == rs2) && (rs2 != '0)) src2 = ex_wdata_i;
    else if (mem_wreg_i && (mem_wd_i == rs2) && (rs2 != '0))       src2 = mem_wdata_i;
  end
`else
  assign src1 = reg1_data_i;
  assign src2 = reg2_data_i;
`endif

  assign op1 = rd1 ? src1 : '0;
  assign op2 = rd2 ? src2 : '0;

  id_branch_unit #(.XLEN(XLEN)) u_branch (
    .opcode_i   (opc),
    .funct3_i   (f3),
    .pc_i       (pc_i),
    .op1_i      (op1),
    .op2_i      (op2),
    .imm_i      (imm),
    .take_c_o   (take_c),
    .target_c_o (target_c)
  );

  assign hazard = ex_load_i && (ex_wd_i != '0) &&
                  ((rd1 && (rs1 == ex_wd_i)) || (rd2 && (rs2 == ex_wd_i)));

  // While squashing, only the redirect target is a real beat; everything else is drained.
  assign tgt_hit    = (pc_i == tgt_q);
  assign run_beat   = (state_q == ST_RUN) || tgt_hit;
  assign norm_ready = !flush_i && !hazard && (!valid_q || out_ready);
  assign in_ready   = !rst && (run_beat ? norm_ready : !flush_i);
  assign fire       = in_valid && in_ready && run_beat;

  assign redirect_o      = fire && take_c;
  assign redirect_addr_o = redirect_o ? target_c : '0;

  always_comb begin
    state_d = state_q;
    tgt_d   = tgt_q;
    valid_d = valid_q;
    pc_d    = pc_q;
    reg1_d  = reg1_q;
    reg2_d  = reg2_q;
    imm_d   = imm_q;
    opc_d   = opc_q;
    f3_d    = f3_q;
    wd_d    = wd_q;
    wreg_d  = wreg_q;
    ill_d   = ill_q;
    if (flush_i) begin
      valid_d = 1'b0;
      state_d = ST_RUN;
    end else if (fire) begin
      valid_d = 1'b1;
      pc_d    = pc_i;
      reg1_d  = op1;
      reg2_d  = op2;
      imm_d   = imm;
      opc_d   = opc;
      f3_d    = f3;
      wd_d    = rd;
      wreg_d  = known && (rd != '0) && (opc != OPC_BRANCH) && (opc != OPC_STORE);
      ill_d   = !known;
      if (take_c) begin
        state_d = ST_SQUASH;
        tgt_d   = target_c;
      end else begin
        state_d = ST_RUN;
      end
    end else if (out_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_RUN;
      tgt_q   <= '0;
      valid_q <= 1'b0;
      pc_q    <= '0;
      reg1_q  <= '0;
      reg2_q  <= '0;
      imm_q   <= '0;
      opc_q   <= '0;
      f3_q    <= '0;
      wd_q    <= '0;
      wreg_q  <= 1'b0;
      ill_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      tgt_q   <= tgt_d;
      valid_q <= valid_d;
      pc_q    <= pc_d;
      reg1_q  <= reg1_d;
      reg2_q  <= reg2_d;
      imm_q   <= imm_d;
      opc_q   <= opc_d;
      f3_q    <= f3_d;
      wd_q    <= wd_d;
      wreg_q  <= wreg_d;
      ill_q   <= ill_d;
    end
  end

  assign out_valid = valid_q;
  assign pc_o      = pc_q;
  assign reg1_o    = reg1_q;
  assign reg2_o    = reg2_q;
  assign imm_o     = imm_q;
  assign opcode_o  = opc_q;
  assign funct_o   = f3_q;
  assign wd_o      = wd_q;
  assign wreg_o    = wreg_q;
  assign illegal_o = ill_q;

endmodule

// File: tb/tb_id_stage_hs.sv
// Directed testbench for id_stage_hs: reset, decode, branch/jump redirect and squash,
// load-use stall, backpressure and flush, with hand-computed expectations.
module tb_id_stage_hs;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned RAW_W = 5;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid, in_ready;
  logic [XLEN-1:0]  pc_i;
  logic [31:0]      inst_i;
  logic [RAW_W-1:0] reg1_addr_o, reg2_addr_o;
  logic [XLEN-1:0]  reg1_data_i, reg2_data_i;
  logic             ex_load_i;
  logic [RAW_W-1:0] ex_wd_i;
  logic             flush_i, out_valid, out_ready;
  logic [XLEN-1:0]  pc_o, reg1_o, reg2_o, imm_o;
  logic [6:0]       opcode_o;
  logic [2:0]       funct_o;
  logic [RAW_W-1:0] wd_o;
  logic             wreg_o, illegal_o, redirect_o;
  logic [XLEN-1:0]  redirect_addr_o;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  id_stage_hs #(.XLEN(XLEN), .RAW_W(RAW_W)) dut (
    .clk             (clk),
    .rst             (rst),
    .in_valid        (in_valid),
    .in_ready        (in_ready),
    .pc_i            (pc_i),
    .inst_i          (inst_i),
    .reg1_addr_o     (reg1_addr_o),
    .reg2_addr_o     (reg2_addr_o),
    .reg1_data_i     (reg1_data_i),
    .reg2_data_i     (reg2_data_i),
    .ex_load_i       (ex_load_i),
    .ex_wd_i         (ex_wd_i),
`ifdef ID_FWD_EN
    .ex_wreg_i       (1'b0),
    .ex_wdata_i      ('0),
    .mem_wreg_i      (1'b0),
    .mem_wd_i        ('0),
    .mem_wdata_i     ('0),
`endif
    .flush_i         (flush_i),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .pc_o            (pc_o),
    .reg1_o          (reg1_o),
    .reg2_o          (reg2_o),
    .imm_o           (imm_o),
    .opcode_o        (opcode_o),
    .funct_o         (funct_o),
    .wd_o            (wd_o),
    .wreg_o          (wreg_o),
    .illegal_o       (illegal_o),
    .redirect_o      (redirect_o),
    .redirect_addr_o (redirect_addr_o)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic [31:0] pc, input logic [31:0] inst,
                      input logic [31:0] r1, input logic [31:0] r2);
    in_valid    = 1'b1;
    pc_i        = pc;
    inst_i      = inst;
    reg1_data_i = r1;
    reg2_data_i = r2;
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    beat(32'h0, 32'h00500093, 32'h0, 32'h0);
    for (int i = 0; i < 2; i++) begin
      n_tests++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL rst_in_ready: got %b exp 0", in_ready); end
      n_tests++; if (redirect_o !== 1'b0) begin n_fail++; $display("FAIL rst_redirect: got %b exp 0", redirect_o); end
      tick();
      n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_out_valid: got %b exp 0", out_valid); end
    end
    n_tests++; if (pc_o !== 32'h0 || wreg_o !== 1'b0) begin n_fail++; $display("FAIL rst_regs: pc_o %h wreg %b exp 0/0", pc_o, wreg_o); end
    rst = 1'b0;
    in_valid = 1'b0;
    #1;
    n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL rst_release_ready: got %b exp 1", in_ready); end
  endtask

  task automatic test_addi();
    beat(32'h0, 32'h00500093, 32'h0, 32'h0);
    n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL addi_ready: got %b exp 1", in_ready); end
    tick();
    in_valid = 1'b0;
    n_tests++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL addi_valid: got %b exp 1", out_valid); end
    n_tests++; if (wd_o !== 5'd1 || wreg_o !== 1'b1) begin n_fail++; $display("FAIL addi_wd: wd %0d wreg %b exp 1/1", wd_o, wreg_o); end
    n_tests++; if (imm_o !== 32'd5 || reg1_o !== 32'd0) begin n_fail++; $display("FAIL addi_ops: imm %h reg1 %h exp 5/0", imm_o, reg1_o); end
    n_tests++; if (opcode_o !== 7'h13 || illegal_o !== 1'b0) begin n_fail++; $display("FAIL addi_opc: %h ill %b exp 13/0", opcode_o, illegal_o); end
    tick();
    n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL addi_drain: got %b exp 0", out_valid); end
  endtask

  task automatic test_branch_squash();
    beat(32'h100, 32'h00208463, 32'd7, 32'd7);
    n_tests++; if (redirect_o !== 1'b1 || redirect_addr_o !== 32'h108) begin n_fail++; $display("FAIL beq_redirect: %b %h exp 1/108", redirect_o, redirect_addr_o); end
    tick();
    n_tests++; if (out_valid !== 1'b1 || imm_o !== 32'd8 || reg2_o !== 32'd7 || wreg_o !== 1'b0) begin n_fail++; $display("FAIL beq_out: v%b imm %h r2 %h wreg %b exp 1/8/7/0", out_valid, imm_o, reg2_o, wreg_o); end
    beat(32'h104, 32'h00700113, 32'd0, 32'd0);
    n_tests++; if (in_ready !== 1'b1 || redirect_o !== 1'b0) begin n_fail++; $display("FAIL squash_drop_ready: rdy %b redir %b exp 1/0", in_ready, redirect_o); end
    tick();
    n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL squash_drop: got %b exp 0", out_valid); end
    beat(32'h108, 32'h00700113, 32'd0, 32'd0);
    n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL squash_hit_ready: got %b exp 1", in_ready); end
    tick();
    n_tests++; if (out_valid !== 1'b1 || pc_o !== 32'h108 || wd_o !== 5'd2 || imm_o !== 32'd7) begin n_fail++; $display("FAIL squash_hit: v%b pc %h wd %0d imm %h exp 1/108/2/7", out_valid, pc_o, wd_o, imm_o); end
  endtask

  task automatic test_branch_cmp();
    beat(32'h140, 32'h00209463, 32'd7, 32'd7);
    n_tests++; if (redirect_o !== 1'b0 || redirect_addr_o !== 32'h0) begin n_fail++; $display("FAIL bne_eq: %b %h exp 0/0", redirect_o, redirect_addr_o); end
    tick();
    beat(32'h144, 32'h0020E463, 32'hFFFF_FFFF, 32'd1);
    n_tests++; if (redirect_o !== 1'b0) begin n_fail++; $display("FAIL bltu_not_taken: got %b exp 0", redirect_o); end
    tick();
    n_tests++; if (pc_o !== 32'h144 || reg1_o !== 32'hFFFF_FFFF || reg2_o !== 32'd1) begin n_fail++; $display("FAIL bltu_out: pc %h r1 %h r2 %h", pc_o, reg1_o, reg2_o); end
  endtask

  task automatic test_jump();
    beat(32'h200, 32'h008000EF, 32'd0, 32'd0);
    n_tests++; if (redirect_o !== 1'b1 || redirect_addr_o !== 32'h208) begin n_fail++; $display("FAIL jal_redirect: %b %h exp 1/208", redirect_o, redirect_addr_o); end
    tick();
    n_tests++; if (wd_o !== 5'd1 || wreg_o !== 1'b1 || imm_o !== 32'd8 || reg1_o !== 32'd0) begin n_fail++; $display("FAIL jal_out: wd %0d wreg %b imm %h r1 %h", wd_o, wreg_o, imm_o, reg1_o); end
    beat(32'h208, 32'h00508067, 32'h200, 32'h55);
    n_tests++; if (redirect_o !== 1'b1 || redirect_addr_o !== 32'h204) begin n_fail++; $display("FAIL jalr_redirect: %b %h exp 1/204", redirect_o, redirect_addr_o); end
    tick();
    n_tests++; if (pc_o !== 32'h208 || wreg_o !== 1'b0 || reg1_o !== 32'h200 || reg2_o !== 32'h0) begin n_fail++; $display("FAIL jalr_out: pc %h wreg %b r1 %h r2 %h", pc_o, wreg_o, reg1_o, reg2_o); end
    beat(32'h204, 32'h00000013, 32'd0, 32'd0);
    n_tests++; if (redirect_o !== 1'b0 || in_ready !== 1'b1) begin n_fail++; $display("FAIL jalr_tgt_ready: redir %b rdy %b exp 0/1", redirect_o, in_ready); end
    tick();
    n_tests++; if (out_valid !== 1'b1 || pc_o !== 32'h204 || wreg_o !== 1'b0) begin n_fail++; $display("FAIL jalr_tgt_out: v%b pc %h wreg %b", out_valid, pc_o, wreg_o); end
  endtask

  task automatic test_hazard();
    ex_load_i = 1'b1;
    ex_wd_i   = 5'd1;
    beat(32'h300, 32'h002081B3, 32'd3, 32'd4);
    n_tests++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL hz_rs1_stall: got %b exp 0", in_ready); end
    tick();
    n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL hz_bubble: got %b exp 0", out_valid); end
    ex_wd_i = 5'd0;
    #1;
    n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL hz_x0: got %b exp 1", in_ready); end
    ex_wd_i = 5'd2;
    #1;
    n_tests++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL hz_rs2_stall: got %b exp 0", in_ready); end
    ex_load_i = 1'b0;
    #1;
    n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL hz_release: got %b exp 1", in_ready); end
    tick();
    n_tests++; if (out_valid !== 1'b1 || wd_o !== 5'd3 || reg1_o !== 32'd3 || reg2_o !== 32'd4 || opcode_o !== 7'h33) begin n_fail++; $display("FAIL hz_out: v%b wd %0d r1 %h r2 %h opc %h", out_valid, wd_o, reg1_o, reg2_o, opcode_o); end
    ex_wd_i = 5'd0;
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    beat(32'h400, 32'h00700113, 32'd0, 32'd0);
    for (int i = 0; i < 3; i++) begin
      n_tests++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_ready[%0d]: got %b exp 0", i, in_ready); end
      tick();
      n_tests++; if (out_valid !== 1'b1 || pc_o !== 32'h300 || reg1_o !== 32'd3 || wd_o !== 5'd3) begin n_fail++; $display("FAIL bp_hold[%0d]: v%b pc %h r1 %h wd %0d", i, out_valid, pc_o, reg1_o, wd_o); end
    end
    out_ready = 1'b1;
    #1;
    n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_resume_ready: got %b exp 1", in_ready); end
    tick();
    n_tests++; if (out_valid !== 1'b1 || pc_o !== 32'h400 || wd_o !== 5'd2) begin n_fail++; $display("FAIL bp_resume: v%b pc %h wd %0d exp 1/400/2", out_valid, pc_o, wd_o); end
  endtask

  task automatic test_illegal();
    beat(32'h480, 32'h0000017F, 32'd9, 32'd9);
    n_tests++; if (redirect_o !== 1'b0) begin n_fail++; $display("FAIL ill_redirect: got %b exp 0", redirect_o); end
    tick();
    n_tests++; if (illegal_o !== 1'b1 || wreg_o !== 1'b0 || imm_o !== 32'h0 || reg1_o !== 32'h0) begin n_fail++; $display("FAIL ill_out: ill %b wreg %b imm %h r1 %h", illegal_o, wreg_o, imm_o, reg1_o); end
  endtask

  task automatic test_flush();
    beat(32'h500, 32'h0020C463, 32'hFFFF_FFFF, 32'd1);
    n_tests++; if (redirect_o !== 1'b1 || redirect_addr_o !== 32'h508) begin n_fail++; $display("FAIL blt_redirect: %b %h exp 1/508", redirect_o, redirect_addr_o); end
    tick();
    flush_i = 1'b1;
    beat(32'h508, 32'h00700113, 32'd0, 32'd0);
    n_tests++; if (in_ready !== 1'b0 || redirect_o !== 1'b0) begin n_fail++; $display("FAIL flush_comb: rdy %b redir %b exp 0/0", in_ready, redirect_o); end
    tick();
    n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_valid: got %b exp 0", out_valid); end
    flush_i = 1'b0;
    beat(32'h600, 32'h00700113, 32'd0, 32'd0);
    tick();
    in_valid = 1'b0;
    n_tests++; if (out_valid !== 1'b1 || pc_o !== 32'h600 || illegal_o !== 1'b0) begin n_fail++; $display("FAIL flush_run: v%b pc %h ill %b exp 1/600/0", out_valid, pc_o, illegal_o); end
  endtask

  initial begin
    rst         = 1'b1;
    in_valid    = 1'b0;
    pc_i        = '0;
    inst_i      = '0;
    reg1_data_i = '0;
    reg2_data_i = '0;
    ex_load_i   = 1'b0;
    ex_wd_i     = '0;
    flush_i     = 1'b0;
    out_ready   = 1'b1;
    @(negedge clk);
    test_reset();
    test_addi();
    test_branch_squash();
    test_branch_cmp();
    test_jump();
    test_hazard();
    test_backpressure();
    test_illegal();
    test_flush();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/id_stage_hs.md
Name: id_stage_hs

Overview:
Registered, handshaked RISC-V RV32I decode stage that sits between the IF/ID and ID/EX pipeline boundaries, with the ID/EX register folded in.
- Decodes fields and immediates, reads the register file and resolves JAL/JALR/branches in ID.
- Detects load-use hazards and squashes wrong-path fetches after a redirect.
- Generalises the earlier combinational decoder with XLEN parametrisation, valid/ready flow control, flush and a squash state machine.

Parameters:
XLEN, 32, datapath/PC width (instruction width fixed at 32)
RAW_W, 5, register address width

Ports:
clk  in  1  clock
rst  in  1  reset; synchronous, active-high
in_valid  in  1  IF/ID beat valid
in_ready  out  1  ID accepts beat this cycle
pc_i  in  XLEN  beat PC
inst_i  in  32  beat instruction
reg1_addr_o  out  RAW_W  rs1 (inst_i[19:15])
reg2_addr_o  out  RAW_W  rs2 (inst_i[24:20])
reg1_data_i  in  XLEN  regfile rs1 data
reg2_data_i  in  XLEN  regfile rs2 data
ex_load_i  in  1  EX stage holds a load
ex_wd_i  in  RAW_W  EX stage destination
flush_i  in  1  kill ID contents (exception/late redirect)
out_valid  out  1  ID/EX register valid
out_ready  in  1  EX accepts
pc_o, reg1_o, reg2_o, imm_o  out  XLEN  registered operands
opcode_o  out  7; funct_o  out  3; wd_o  out  RAW_W; wreg_o  out  1; illegal_o  out  1
redirect_o  out  1  combinational pulse: fetch redirect
redirect_addr_o  out  XLEN  redirect target

Behaviour:
- Reset (sync): out_valid=0, all registered outputs 0, state=RUN, redirect_o=0.
- Decode is combinational on inst_i, using the I/S/B/U/J immediate formats, sign-extended to XLEN.
- reg1 is read for JALR/B/L/S/OP-IMM/OP; reg2 is read for B/S/OP. An unread operand is forced to 0.
- wreg_o=0 when rd==0, for B/S, or for an unknown opcode. An unknown opcode sets illegal_o=1.
- hazard = ex_load_i && ex_wd_i!=0 && ((rd1 && rs1==ex_wd_i) || (rd2 && rs2==ex_wd_i)).
- in_ready = !flush_i && !hazard && (!out_valid || out_ready). In SQUASH, in_ready = !flush_i.
- fire = in_valid && in_ready && state==RUN. On fire, the output regs load and out_valid=1 on the next edge (1-cycle latency).
- When out_ready && !fire: out_valid←0. A hazard therefore inserts exactly one bubble per stalled cycle.
- When out_valid && !out_ready: all outputs hold stable.
- Redirect is asserted only on fire:
  - JAL: pc+immJ.
  - JALR: (reg1+immI) with bit0 cleared.
  - Branch taken: pc+immB. BEQ/BNE/BLT/BGE compare signed; BLTU/BGEU compare unsigned; an unused funct3 is not taken.
  - When not redirecting, redirect_addr_o=0.
- State machine:
  - RUN→SQUASH on fire with redirect; the target is latched into tgt.
  - In SQUASH, every in_valid beat with pc_i!=tgt is consumed and dropped: no output, no redirect.
  - A beat with pc_i==tgt causes SQUASH→RUN in the same cycle, and the beat is treated as a normal fire, subject to hazard/backpressure. If stalled it is not consumed.
- flush_i (highest priority): next edge out_valid=0, state=RUN; the input beat is not accepted and there is no redirect.
- Arithmetic wraps modulo 2^XLEN.

Optional Feature:
ID_FWD_EN:
- Defined: adds ports ex_wreg_i, ex_wdata_i[XLEN], mem_wreg_i, mem_wd_i[RAW_W], mem_wdata_i[XLEN].
- reg1/reg2 take the EX result when ex_wreg_i && !ex_load_i && addr match && addr!=0; otherwise the MEM result on match; otherwise the regfile. EX has priority.
- Forwarded values feed both the operands and the branch compare. Load-use stall is still applied.
- Undefined: regfile data is used raw; the ports are absent.

Decomposition:
- Shared package/defines: opcode constants (LUI, AUIPC, JAL, JALR, B, L, S, OP_IMM, OP), branch funct3 codes, state encoding (RUN/SQUASH).
- One natural sub-module: id_branch_unit (compare + target + redirect decision), purely combinational.

Test Plan:
- rst held 2 cycles, in_valid=1 → out_valid=0, redirect_o=0, in_ready=0 during rst; state=RUN after release.
- inst 0x00500093 (addi x1,x0,5), pc 0x0, out_ready=1 → next cycle out_valid=1, wd_o=1, imm_o=5, wreg_o=1, reg1_o=0.
- inst 0x00208463 (beq x1,x2,+8) at pc 0x100, reg1=reg2=7 → redirect_o=1, redirect_addr_o=0x108. Beats at pc 0x104/0x108 follow → 0x104 dropped, 0x108 emitted next cycle.
- ex_load_i=1, ex_wd_i=1, inst 0x002081B3 (add x3,x1,x2) → in_ready=0, one bubble. Drop ex_load_i → accepted, out_valid=1.
- out_valid=1, out_ready=0 for 3 cycles → in_ready=0, all outputs stable. Then out_ready=1 → next beat accepted.
- State SQUASH, flush_i=1 with in_valid=1 at pc==tgt → beat not accepted, out_valid=0, state=RUN, redirect_o=0.
